// File: rtl/nes_rgb_quantizer.sv
// -----------------------------------------------------------------------------
// nes_rgb_quantizer
//
// Maps a 12-bit RGB colour onto the nearest entry of the 64-entry NES master
// palette. One palette entry is scored per clock (squared Euclidean distance),
// and the lowest-index entry with the smallest distance wins.
//
// Optional feature (macro QUANT_EARLY_EXIT_EN):
//   when defined, the scan stops at the first entry with distance 0.
//   When undefined, every request takes exactly 64 cycles.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-low reset
//   in_valid   request strobe, rgb_in valid
//   in_ready   request accepted when high (IDLE only)
//   rgb_in     [11:8] R, [7:4] G, [3:0] B
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_index  nearest palette index (held after the handshake)
//   out_exact  winning distance was zero
//   busy       search in progress or result pending
// -----------------------------------------------------------------------------
module nes_rgb_quantizer #(
  parameter int DIST_W = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] rgb_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_index,
  output logic        out_exact,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Master palette ROM, one 12-bit RGB value per index.
  function automatic logic [11:0] palette_rom(input logic [5:0] idx);
    logic [11:0] c;
    case (idx)
      6'h00: c = 12'h333; 6'h01: c = 12'h014; 6'h02: c = 12'h006; 6'h03: c = 12'h326;
      6'h04: c = 12'h403; 6'h05: c = 12'h503; 6'h06: c = 12'h510; 6'h07: c = 12'h420;
      6'h08: c = 12'h320; 6'h09: c = 12'h120; 6'h0A: c = 12'h031; 6'h0B: c = 12'h040;
      6'h0C: c = 12'h022; 6'h0D: c = 12'h000; 6'h0E: c = 12'h000; 6'h0F: c = 12'h000;
      6'h10: c = 12'h555; 6'h11: c = 12'h036; 6'h12: c = 12'h027; 6'h13: c = 12'h407;
      6'h14: c = 12'h507; 6'h15: c = 12'h704; 6'h16: c = 12'h700; 6'h17: c = 12'h630;
      6'h18: c = 12'h430; 6'h19: c = 12'h140; 6'h1A: c = 12'h040; 6'h1B: c = 12'h053;
      6'h1C: c = 12'h044; 6'h1D: c = 12'h000; 6'h1E: c = 12'h000; 6'h1F: c = 12'h000;
      6'h20: c = 12'h777; 6'h21: c = 12'h357; 6'h22: c = 12'h447; 6'h23: c = 12'h637;
      6'h24: c = 12'h707; 6'h25: c = 12'h737; 6'h26: c = 12'h740; 6'h27: c = 12'h750;
      6'h28: c = 12'h660; 6'h29: c = 12'h360; 6'h2A: c = 12'h070; 6'h2B: c = 12'h276;
      6'h2C: c = 12'h077; 6'h2D: c = 12'h000; 6'h2E: c = 12'h000; 6'h2F: c = 12'h000;
      6'h30: c = 12'h777; 6'h31: c = 12'h567; 6'h32: c = 12'h657; 6'h33: c = 12'h757;
      6'h34: c = 12'h747; 6'h35: c = 12'h755; 6'h36: c = 12'h764; 6'h37: c = 12'h772;
      6'h38: c = 12'h773; 6'h39: c = 12'h572; 6'h3A: c = 12'h473; 6'h3B: c = 12'h276;
      6'h3C: c = 12'h467; 6'h3D: c = 12'h000; 6'h3E: c = 12'h000; 6'h3F: c = 12'h000;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // Square of a 5-bit signed channel difference; magnitude is at most 15,
  // so the square always fits in 8 bits.
  function automatic logic [7:0] chan_sq(input logic [3:0] a, input logic [3:0] b);
    logic signed [4:0] d;
    logic        [4:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = d[4] ? (5'd0 - d) : d;
    return {4'd0, m[3:0]} * {4'd0, m[3:0]};
  endfunction

  // Squared distance between two 12-bit colours, no saturation.
  function automatic logic [DIST_W-1:0] rgb_dist(input logic [11:0] a, input logic [11:0] b);
    return DIST_W'(chan_sq(a[11:8], b[11:8]))
         + DIST_W'(chan_sq(a[7:4],  b[7:4]))
         + DIST_W'(chan_sq(a[3:0],  b[3:0]));
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [11:0]         rgb_r;
  logic [5:0]          ptr_r;
  logic [DIST_W-1:0]   best_dist_r;
  logic [5:0]          best_idx_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                busy_r;
  logic [5:0]          out_index_r;
  logic                out_exact_r;

  logic [DIST_W-1:0]   cand_dist_s;
  logic                better_s;
  logic [DIST_W-1:0]   new_best_dist_s;
  logic [5:0]          new_best_idx_s;
  logic                last_s;
  logic                hit_s;
  logic                finish_s;

  // Score the current entry and pick the next state.
  always_comb begin
    state_next_s    = state_r;
    cand_dist_s     = rgb_dist(rgb_r, palette_rom(ptr_r));
    better_s        = (cand_dist_s < best_dist_r);
    new_best_dist_s = better_s ? cand_dist_s : best_dist_r;
    new_best_idx_s  = better_s ? ptr_r : best_idx_r;
    last_s          = (ptr_r == 6'd63);
`ifdef QUANT_EARLY_EXIT_EN
    // The first zero-distance entry is the lowest-index exact match and
    // cannot be beaten by anything later in the table.
    hit_s           = (cand_dist_s == {DIST_W{1'b0}});
`else
    hit_s           = 1'b0;
`endif
    finish_s        = last_s | hit_s;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_SEARCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (finish_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SEARCH;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= ST_IDLE;
      rgb_r       <= 12'h000;
      ptr_r       <= 6'd0;
      best_dist_r <= {DIST_W{1'b1}};
      best_idx_r  <= 6'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_index_r <= 6'd0;
      out_exact_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      // Flags track the state being entered so they line up with state_r.
      in_ready_r  <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);

      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            rgb_r       <= rgb_in;
            ptr_r       <= 6'd0;
            best_dist_r <= {DIST_W{1'b1}};
            best_idx_r  <= 6'd0;
          end
        end
        ST_SEARCH: begin
          best_dist_r <= new_best_dist_s;
          best_idx_r  <= new_best_idx_s;
          if (finish_s) begin
            // Result registers load once and stay put until the next search ends.
            out_index_r <= new_best_idx_s;
            out_exact_r <= (new_best_dist_s == {DIST_W{1'b0}});
          end else begin
            ptr_r <= ptr_r + 6'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_index = out_index_r;
  assign out_exact = out_exact_r;

endmodule

// File: tb/tb_nes_rgb_quantizer.sv
// Self-checking bench for nes_rgb_quantizer: directed cases plus random
// colours checked against a brute-force nearest-colour model.
module tb_nes_rgb_quantizer;

  logic        CLK;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] rgb_in;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic        out_exact;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [11:0] pal [64] = '{
    12'h333,12'h014,12'h006,12'h326,12'h403,12'h503,12'h510,12'h420,
    12'h320,12'h120,12'h031,12'h040,12'h022,12'h000,12'h000,12'h000,
    12'h555,12'h036,12'h027,12'h407,12'h507,12'h704,12'h700,12'h630,
    12'h430,12'h140,12'h040,12'h053,12'h044,12'h000,12'h000,12'h000,
    12'h777,12'h357,12'h447,12'h637,12'h707,12'h737,12'h740,12'h750,
    12'h660,12'h360,12'h070,12'h276,12'h077,12'h000,12'h000,12'h000,
    12'h777,12'h567,12'h657,12'h757,12'h747,12'h755,12'h764,12'h772,
    12'h773,12'h572,12'h473,12'h276,12'h467,12'h000,12'h000,12'h000};

  nes_rgb_quantizer #(.DIST_W(10)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rgb_in    (rgb_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_exact (out_exact),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Brute-force nearest colour: first index with the smallest squared distance.
  function automatic void model(input logic [11:0] rgb, output int idx,
                                output bit exact, output int lat);
    int best;
    int d, dr, dg, db;
    bit found;
    best  = 1 << 20;
    idx   = 0;
    lat   = 64;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dr = int'(rgb[11:8]) - int'(pal[i][11:8]);
      dg = int'(rgb[7:4])  - int'(pal[i][7:4]);
      db = int'(rgb[3:0])  - int'(pal[i][3:0]);
      d  = dr*dr + dg*dg + db*db;
      if (d < best) begin
        best = d;
        idx  = i;
      end
`ifdef QUANT_EARLY_EXIT_EN
      if (d == 0 && !found) begin
        lat   = i + 1;
        found = 1'b1;
      end
`endif
    end
    exact = (best == 0);
  endfunction

  // Waits (bounded) for out_valid; returns cycles since the acceptance edge.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  // One full request; hold>0 keeps out_ready low for that many cycles while
  // in_valid toggles with a different colour.
  task automatic run_req(input logic [11:0] rgb, input int exp_idx,
                         input bit exp_exact, input int hold);
    int mi, lat_exp, cyc;
    bit me;
    model(rgb, mi, me, lat_exp);
    @(negedge CLK);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    rgb_in   = rgb;
    @(negedge CLK);
    in_valid = 1'b0;
    rgb_in   = 12'($urandom);
    check("busy_after_accept", busy, 1);
    check("in_ready_busy", in_ready, 0);
    wait_result(cyc);
    check("latency", cyc, lat_exp);
    check("index", out_index, exp_idx);
    check("exact", out_exact, exp_exact);
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      rgb_in   = 12'h000;
      @(negedge CLK);
      check("hold_valid", out_valid, 1);
      check("hold_index", out_index, exp_idx);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
    check("post_hs_busy", busy, 0);
    check("post_hs_index", out_index, exp_idx);
    check("post_hs_exact", out_exact, exp_exact);
  endtask

  initial begin
    int mi, ml, i1, l1, i2, l2, cyc;
    bit me, e1, e2;
    logic [11:0] r;

    RESET     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rgb_in    = 12'h000;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_index", out_index, 0);
    check("rst_exact", out_exact, 0);
    check("rst_busy", busy, 0);
    @(negedge CLK);
    RESET = 1'b1;

    // Directed colours from the palette boundaries and duplicates.
    run_req(12'h333, 6'h00, 1'b1, 0);
    run_req(12'h000, 6'h0D, 1'b1, 0);
    run_req(12'hFFF, 6'h20, 1'b0, 0);
    run_req(12'h776, 6'h20, 1'b0, 0);
    run_req(12'h276, 6'h2B, 1'b1, 0);

    // Back-pressure with a competing request toggled on in_valid.
    run_req(12'h704, 6'h15, 1'b1, 10);

    // Back-to-back with out_ready held high and in_valid never dropped.
    model(12'h740, i1, e1, l1);
    model(12'h077, i2, e2, l2);
    @(negedge CLK);
    in_valid  = 1'b1;
    rgb_in    = 12'h740;
    out_ready = 1'b1;
    @(negedge CLK);
    rgb_in = 12'h077;
    wait_result(cyc);
    check("b2b_lat1", cyc, l1);
    check("b2b_idx1", out_index, i1);
    check("b2b_idx1_const", out_index, 6'h26);
    @(negedge CLK);
    check("b2b_gap_valid", out_valid, 0);
    check("b2b_gap_ready", in_ready, 1);
    @(negedge CLK);
    in_valid = 1'b0;
    check("b2b_second_busy", busy, 1);
    check("b2b_second_ready", in_ready, 0);
    wait_result(cyc);
    check("b2b_lat2", cyc, l2);
    check("b2b_idx2", out_index, 6'h2C);
    check("b2b_exact2", out_exact, e2);
    @(negedge CLK);
    out_ready = 1'b0;
    check("b2b_done_valid", out_valid, 0);

    // Reset mid-search on a colour with no exact match.
    @(negedge CLK);
    in_valid = 1'b1;
    rgb_in   = 12'h123;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (30) @(negedge CLK);
    check("pre_rst_busy", busy, 1);
    RESET = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge CLK);
    RESET = 1'b1;
    run_req(12'h473, 6'h3A, 1'b1, 0);

    // Random colours against the model.
    for (int n = 0; n < 16; n++) begin
      r = 12'($urandom);
      model(r, mi, me, ml);
      run_req(r, mi, me, n % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
